// File: rtl/arbitro_1_rr.sv
// -----------------------------------------------------------------------------
// arbitro_1_rr
//   Round-robin merge arbiter. It drains four class FIFOs into one shared
//   downstream FIFO. Each cycle it pops at most one entry from the granted
//   input FIFO. That entry is pushed downstream on the following cycle.
//   A grant lasts for at most BURST consecutive pops. After that the arbiter
//   moves on to the next non-empty port.
//
// Parameters
//   DATA_W       width of one FIFO entry (class bits included)
//   BURST        max consecutive pops per grant before advancing (>=1)
//
// Ports
//   clk          clock, all state on posedge
//   reset        synchronous, active-low
//   Enable       1 = arbitrate; 0 = freeze state, no Pop, no Push
//   FIFO_empty   empty flag of input FIFO i (bit i)
//   Data_in      show-ahead read data, port i = [i*DATA_W +: DATA_W]
//   Almost_full  downstream FIFO almost full (stalls the grant)
//   Pop          one-hot pop to input FIFO i (combinational)
//   Push         push to downstream FIFO (registered)
//   Data_out     entry pushed this cycle (registered)
//   Src_out      index of the port Data_out came from (registered)
// -----------------------------------------------------------------------------
module arbitro_1_rr #(
  parameter int DATA_W = 6,
  parameter int BURST  = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Enable,
  input  logic [3:0]          FIFO_empty,
  input  logic [4*DATA_W-1:0] Data_in,
  input  logic                Almost_full,
  output logic [3:0]          Pop,
  output logic                Push,
  output logic [DATA_W-1:0]   Data_out,
  output logic [1:0]          Src_out
);

  localparam int CNT_W = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t              state_reg;
  logic [1:0]          ptr_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic                push_reg;
  logic [DATA_W-1:0]   data_out_reg;
  logic [1:0]          src_out_reg;

  logic [DATA_W-1:0]   data_slice [4];
  logic [3:0]          cand_ne;      // cand_ne[k]: port ptr+1+k holds data
  logic                found_next;
  logic [1:0]          next_ptr;
  logic                popped;
  logic                cnt_last;

  // Split the read bus into per-port slices. Build the rotated
  // non-empty vector, ordered by round-robin distance from ptr.
  // The last slot (k=3) is ptr itself, so a port that is the only
  // one holding data gets re-granted.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      logic [1:0] idx;
      assign data_slice[gi] = Data_in[gi*DATA_W +: DATA_W];
      assign idx            = ptr_reg + 2'(gi + 1);
      assign cand_ne[gi]    = ~FIFO_empty[idx];
      assign Pop[gi]        = popped & (ptr_reg == 2'(gi));
    end
  endgenerate

  // First non-empty port in round-robin order after ptr.
  // The loop runs downward so that the nearest candidate wins.
  always_comb begin
    found_next = 1'b0;
    next_ptr   = ptr_reg;
    for (int k = 3; k >= 0; k--) begin
      if (cand_ne[k]) begin
        found_next = 1'b1;
        next_ptr   = ptr_reg + 2'(k + 1);
      end
    end
  end

  // The pop is Mealy. The empty flag is seen in the same cycle, so an
  // empty FIFO is never popped, even when it emptied on the previous pop.
  assign popped   = Enable & reset & (state_reg == SERVE) &
                    ~FIFO_empty[ptr_reg] & ~Almost_full;
  assign cnt_last = (cnt_reg == CNT_W'(BURST - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= 2'd0;
      cnt_reg      <= '0;
      push_reg     <= 1'b0;
      data_out_reg <= '0;
      src_out_reg  <= 2'd0;
    end else if (Enable) begin
      push_reg <= popped;
      if (popped) begin
        data_out_reg <= data_slice[ptr_reg];
        src_out_reg  <= ptr_reg;
      end
      case (state_reg)
        IDLE: begin
          // Grant only. The first pop happens in the next cycle.
          if (found_next) begin
            state_reg <= SERVE;
            ptr_reg   <= next_ptr;
            cnt_reg   <= '0;
          end
        end
        SERVE: begin
          // While Almost_full is high, the grant and burst count are held.
          if (!Almost_full) begin
            if (popped && !cnt_last) begin
              cnt_reg <= cnt_reg + 1'b1;
            end else begin
              // The burst is exhausted, or the granted port has drained.
              cnt_reg <= '0;
              if (found_next) begin
                ptr_reg <= next_ptr;
              end else begin
                state_reg <= IDLE;
              end
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end else begin
      push_reg <= 1'b0;
    end
  end

  assign Push     = push_reg;
  assign Data_out = data_out_reg;
  assign Src_out  = src_out_reg;

endmodule

// File: tb/tb_arbitro_1_rr.sv
// -----------------------------------------------------------------------------
// tb_arbitro_1_rr
//   Bench for the round-robin merge arbiter. The bench plays the four input
//   FIFOs as queues. A behavioural model tracks the grant in terms of "which
//   port, how many pops so far in this burst". Every cycle the DUT outputs
//   are compared against that model. Hand-written pop orders and data values
//   pin the model for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_arbitro_1_rr;

  localparam int DATA_W = 6;
  localparam int BURST  = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                Enable;
  logic [3:0]          FIFO_empty;
  logic [4*DATA_W-1:0] Data_in;
  logic                Almost_full;
  logic [3:0]          Pop;
  logic                Push;
  logic [DATA_W-1:0]   Data_out;
  logic [1:0]          Src_out;

  always #5 clk = ~clk;

  arbitro_1_rr #(.DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk         (clk),
    .reset       (reset),
    .Enable      (Enable),
    .FIFO_empty  (FIFO_empty),
    .Data_in     (Data_in),
    .Almost_full (Almost_full),
    .Pop         (Pop),
    .Push        (Push),
    .Data_out    (Data_out),
    .Src_out     (Src_out)
  );

  // Input FIFO contents, as seen by the arbiter.
  logic [DATA_W-1:0] fq [4][$];

  // Model state: grant port, pops done in this burst, and whether a grant exists.
  int                m_port    = 0;
  int                m_used    = 0;
  bit                m_granted = 1'b0;
  bit                m_push    = 1'b0;
  logic [DATA_W-1:0] m_dout    = '0;
  int                m_src     = 0;
  bit                m_valid   = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int                log_port [$];
  int                log_cyc  [$];
  logic [DATA_W-1:0] push_data[$];
  int                push_src [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  // First port holding data, walking round-robin from just after p and ending on p.
  function automatic int next_port(input int p);
    for (int k = 1; k <= 4; k++) begin
      if (fq[(p + k) % 4].size() > 0) return (p + k) % 4;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = m_granted;
    for (int i = 0; i < 4; i++) if (fq[i].size() > 0) b = 1'b1;
    return b;
  endfunction

  // One clock cycle: drive FIFO views, compare, clock, advance the model.
  task automatic step();
    int pi;
    int n;
    for (int i = 0; i < 4; i++) begin
      FIFO_empty[i] = (fq[i].size() == 0);
      Data_in[i*DATA_W +: DATA_W] = (fq[i].size() > 0) ? fq[i][0] : '0;
    end
    #2;
    pi = -1;
    if (reset && Enable && m_granted && !Almost_full && fq[m_port].size() > 0)
      pi = m_port;
    chk("pop", int'(Pop), (pi >= 0) ? (1 << pi) : 0);
    if (m_valid) begin
      chk("push", int'(Push), int'(m_push));
      chk("data_out", int'(Data_out), int'(m_dout));
      chk("src_out", int'(Src_out), m_src);
    end
    if (Push) begin
      push_data.push_back(Data_out);
      push_src.push_back(int'(Src_out));
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      m_push = 1'b0; m_dout = '0; m_src = 0;
      m_port = 0; m_used = 0; m_granted = 1'b0; m_valid = 1'b1;
    end else if (Enable) begin
      m_push = (pi >= 0);
      if (pi >= 0) begin
        m_dout = fq[pi][0];
        m_src  = pi;
      end
      if (!m_granted) begin
        n = next_port(m_port);
        if (n >= 0) begin m_granted = 1'b1; m_port = n; m_used = 0; end
      end else if (!Almost_full) begin
        if (pi >= 0) m_used++;
        if (pi < 0 || m_used == BURST) begin
          n = next_port(m_port);
          m_used = 0;
          if (n >= 0) m_port = n;
          else m_granted = 1'b0;
        end
      end
    end else begin
      m_push = 1'b0;
    end
    if (pi >= 0) begin
      $display("cycle %0d pop port %0d entry %02h", cyc, pi, fq[pi][0]);
      log_port.push_back(pi);
      log_cyc.push_back(cyc);
      void'(fq[pi].pop_front());
    end
    cyc++;
  endtask

  task automatic drain();
    int guard = 0;
    while (busy() && guard < 200) begin step(); guard++; end
    chk("drain_bound", int'(guard < 200), 1);
    step(); step();
  endtask

  task automatic step_until_pops(input int n);
    int guard = 0;
    while (log_port.size() < n && guard < 50) begin step(); guard++; end
    chk("pop_wait_bound", int'(guard < 50), 1);
  endtask

  task automatic load(input int p, input int n);
    for (int i = 0; i < n; i++) fq[p].push_back(DATA_W'(p * 16 + i));
  endtask

  task automatic chk_seq(input string name, input int li, input int e[$]);
    chk({name, "_count"}, log_port.size() - li, e.size());
    for (int i = 0; i < e.size(); i++)
      chk(name, (li + i < log_port.size()) ? log_port[li + i] : -1, e[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int li;
    int pli;
    int base;
    int e[$];

    reset = 1'b0; Enable = 1'b1; Almost_full = 1'b0;
    FIFO_empty = '1; Data_in = '0;

    // T1: reset held with all FIFOs loaded, then first grant goes to port 1.
    for (int p = 0; p < 4; p++) load(p, 1);
    for (int r = 0; r < 2; r++) begin
      step();
      chk("t1_reset_push", int'(Push), 0);
      chk("t1_reset_data", int'(Data_out), 0);
      chk("t1_reset_src", int'(Src_out), 0);
    end
    reset = 1'b1;
    li = log_port.size();
    base = cyc;
    drain();
    e = '{1, 2, 3, 0};
    chk_seq("t1_order", li, e);
    chk("t1_first_pop_cycle", log_cyc[li] - base, 1);

    // T2: only port 2 has A,B,C.
    fq[2].push_back(6'h2A); fq[2].push_back(6'h2B); fq[2].push_back(6'h2C);
    li = log_port.size();
    pli = push_data.size();
    drain();
    e = '{2, 2, 2};
    chk_seq("t2_order", li, e);
    chk("t2_contiguous", log_cyc[li + 2] - log_cyc[li], 2);
    chk("t2_push_count", push_data.size() - pli, 3);
    chk("t2_data_a", int'(push_data[pli]), 'h2A);
    chk("t2_data_b", int'(push_data[pli + 1]), 'h2B);
    chk("t2_data_c", int'(push_data[pli + 2]), 'h2C);
    chk("t2_src", push_src[pli + 2], 2);

    // Leave the pointer on port 3 before T3.
    load(3, 1);
    drain();

    // T3: four ports, 6 entries each, starting from pointer 3.
    for (int p = 0; p < 4; p++) load(p, 6);
    li = log_port.size();
    drain();
    e = '{0,0,0,0, 1,1,1,1, 2,2,2,2, 3,3,3,3, 0,0, 1,1, 2,2, 3,3};
    chk_seq("t3_order", li, e);
    chk("t3_no_gap", log_cyc[li + 16] - log_cyc[li], 16);

    // T4: Almost_full stall for 3 cycles after two pops of a burst.
    load(1, 6); load(2, 6);
    li = log_port.size();
    step_until_pops(li + 2);
    Almost_full = 1'b1;
    step(); step(); step();
    Almost_full = 1'b0;
    drain();
    e = '{1,1,1,1, 2,2,2,2, 1,1, 2,2};
    chk_seq("t4_order", li, e);
    chk("t4_stall_gap", log_cyc[li + 2] - log_cyc[li + 1], 4);

    // T5: Enable low for 2 cycles mid-stream.
    load(3, 5); load(0, 2);
    li = log_port.size();
    step_until_pops(li + 2);
    Enable = 1'b0;
    step(); step();
    Enable = 1'b1;
    drain();
    e = '{3,3,3,3, 0,0, 3};
    chk_seq("t5_order", li, e);
    chk("t5_freeze_gap", log_cyc[li + 2] - log_cyc[li + 1], 3);

    // T6: reset pulse mid-burst on port 1. The search restarts from pointer 0.
    load(1, 6); load(2, 1);
    li = log_port.size();
    step_until_pops(li + 2);
    reset = 1'b0;
    step();
    chk("t6_push_after_reset", int'(Push), 0);
    reset = 1'b1;
    drain();
    e = '{1,1, 1,1,1,1, 2};
    chk_seq("t6_order", li, e);
    chk("t6_restart_gap", log_cyc[li + 2] - log_cyc[li + 1], 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
